// File: rtl/ttl_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ttl_bus_arbiter_if
// Brief    : Request/lock inputs and decoder-drive outputs of the bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ttl_bus_arbiter_if #(
    parameter int REQUESTERS = 4,
    parameter int SEL_WIDTH  = 2
);
    logic [REQUESTERS-1:0] Req_bar;
    logic                  Lock_bar;
    logic                  Dec_Enable_bar;
    logic [SEL_WIDTH-1:0]  Dec_A;
    logic [REQUESTERS-1:0] Grant_bar;
    logic                  Busy;

    modport master (
        input  Req_bar,
        input  Lock_bar,
        output Dec_Enable_bar,
        output Dec_A,
        output Grant_bar,
        output Busy
    );

    modport slave (
        output Req_bar,
        output Lock_bar,
        input  Dec_Enable_bar,
        input  Dec_A,
        input  Grant_bar,
        input  Busy
    );
endinterface
`default_nettype wire

// File: rtl/ttl_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ttl_bus_arbiter
// Brief    : Round-robin arbiter for four active-low requesters driving one
//            half of a 2-to-4 inverted decoder, with hold limit, lock and
//            idle turnaround between owners.
// Revision : 1.0 - initial release
// ============================================================================
module ttl_bus_arbiter #(
    parameter int REQUESTERS  = 4,
    parameter int SEL_WIDTH   = $clog2(REQUESTERS),
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  wire logic          Clk,
    input  wire logic          Clear_bar,
    ttl_bus_arbiter_if.master  bus
);

    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(MAX_HOLD);
    localparam logic [3:0]        c_turn     = 4'(TURN_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    dec_a_q, dec_a_d;
    logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [3:0]              turn_q, turn_d;
    logic                    en_bar_q, en_bar_d;
    logic [REQUESTERS-1:0]   grant_bar_q, grant_bar_d;
    logic                    busy_q, busy_d;

    logic                    w_found;
    logic [SEL_WIDTH-1:0]    w_winner;
    logic [SEL_WIDTH-1:0]    w_idx;
    logic [REQUESTERS-1:0]   w_owner_mask;
    logic                    w_others;
    logic                    w_release;
    logic                    w_forced;

    // Scan from the highest offset down so the request closest to ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = ptr_q;
        w_idx    = ptr_q;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            w_idx = ptr_q + SEL_WIDTH'(i);
            if (!bus.Req_bar[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_owner_mask = REQUESTERS'(1) << dec_a_q;
    assign w_others     = |(~bus.Req_bar & ~w_owner_mask);
    assign w_release    = bus.Req_bar[dec_a_q];
    assign w_forced     = (MAX_HOLD != 0) && (hold_q == c_hold_max)
                          && w_others && bus.Lock_bar;

    always_comb begin
        state_d = state_q;
        dec_a_d = dec_a_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d = ST_GRANT;
                    dec_a_d = w_winner;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (w_release || w_forced) begin
                    state_d = ST_TURN;
                    ptr_d   = dec_a_q + SEL_WIDTH'(1);
                    turn_d  = 4'd1;
                end else if (hold_q < c_hold_max) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                if (turn_q >= c_turn) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state, so they track it exactly.
        en_bar_d    = (state_d != ST_GRANT);
        busy_d      = (state_d != ST_IDLE);
        grant_bar_d = en_bar_d ? {REQUESTERS{1'b1}} : ~(REQUESTERS'(1) << dec_a_d);
    end

    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            state_q     <= ST_IDLE;
            dec_a_q     <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
            turn_q      <= '0;
            en_bar_q    <= 1'b1;
            grant_bar_q <= {REQUESTERS{1'b1}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_a_q     <= dec_a_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            turn_q      <= turn_d;
            en_bar_q    <= en_bar_d;
            grant_bar_q <= grant_bar_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.Dec_Enable_bar = en_bar_q;
    assign bus.Dec_A          = dec_a_q;
    assign bus.Grant_bar      = grant_bar_q;
    assign bus.Busy           = busy_q;

endmodule
`default_nettype wire
